// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem offload path.
package fpu_ss_pkg;

  // Width of the CV-X-IF instruction id carried with every offloaded instruction.
  localparam int unsigned FPU_SS_ID_WIDTH = 4;

  // One buffered offload request: instruction word, integer operands and X-IF id.
  typedef struct packed {
    logic [31:0]                instr;
    logic [31:0]                rs1;
    logic [31:0]                rs2;
    logic [FPU_SS_ID_WIDTH-1:0] id;
  } fpu_ss_instr_entry_t;

endpackage : fpu_ss_pkg

// File: rtl/fpu_ss_instr_buffer.sv
// Offload instruction buffer: in-order store of accepted X-IF instructions,
// presented head-first to the controller, with commit-kill entries dropped.
module fpu_ss_instr_buffer
  import fpu_ss_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned ID_WIDTH     = FPU_SS_ID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [31:0]                push_instr_i,
  input  logic [31:0]                push_rs1_i,
  input  logic [31:0]                push_rs2_i,
  input  logic [ID_WIDTH-1:0]        push_id_i,
  input  logic                       kill_valid_i,
  input  logic [ID_WIDTH-1:0]        kill_id_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [31:0]                pop_instr_o,
  output logic [31:0]                pop_rs1_o,
  output logic [31:0]                pop_rs2_o,
  output logic [ID_WIDTH-1:0]        pop_id_o,
  output logic [$clog2(DEPTH):0]     usage_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Stored entries share the package struct, so the id width is tied to it.
  if (ID_WIDTH != FPU_SS_ID_WIDTH) begin : g_bad_id_width
    $error("fpu_ss_instr_buffer: ID_WIDTH must equal FPU_SS_ID_WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fpu_ss_instr_buffer: DEPTH must be a power of two >= 2");
  end

  fpu_ss_instr_entry_t mem_q [DEPTH];
  logic [DEPTH-1:0]    valid_q,  valid_d;
  logic [DEPTH-1:0]    killed_q, killed_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    usage_q,  usage_d;

  fpu_ss_instr_entry_t push_entry;
  fpu_ss_instr_entry_t pop_entry;
  logic                empty;
  logic                full;
  logic                push_hs;
  logic                push_kill;
  logic                bypass;
  logic                pop_valid;
  logic                pop_hs;
  logic                drop;
  logic                advance_rd;
  logic                store;

  assign empty        = (usage_q == '0);
  assign full         = (usage_q == CNT_W'(DEPTH));
  // Ready depends only on state and flush, never on pop_ready_i.
  assign push_ready_o = ~full & ~flush_i;
  assign push_hs      = push_valid_i & push_ready_o;
  assign push_kill    = kill_valid_i & (push_id_i == kill_id_i);

  assign push_entry.instr = push_instr_i;
  assign push_entry.rs1   = push_rs1_i;
  assign push_entry.rs2   = push_rs2_i;
  assign push_entry.id    = push_id_i;

  // An empty buffer forwards the incoming push straight to the pop side.
  assign bypass = FALL_THROUGH & empty & push_hs;

  // Select what the controller sees at the head: bypassed push, stored head or zeros.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pop_valid = 1'b0;
    pop_entry = '0;
    if (bypass) begin
      pop_valid = ~push_kill;
      pop_entry = push_entry;
    end else if (!empty) begin
      pop_valid = ~killed_q[rd_ptr_q];
      pop_entry = mem_q[rd_ptr_q];
    end
  end

  assign pop_hs = pop_valid & pop_ready_i;
  // A killed head is discarded on its own, one entry per cycle.
  assign drop   = ~empty & killed_q[rd_ptr_q];
  // The stored head leaves on a pop or a drop; a bypassed pop never touches storage.
  assign advance_rd = ~empty & (pop_hs | drop);
  // A bypassed push consumed in the same cycle is never written.
  assign store = push_hs & ~(bypass & pop_hs);

  // Next-state for flags, pointers and usage: kill marking, then head release, then push.
  always_comb begin
    valid_d  = valid_q;
    killed_d = killed_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (kill_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (mem_q[i].id == kill_id_i)) begin
          killed_d[i] = 1'b1;
        end
      end
    end

    // Releasing the head clears any kill that arrived in the same cycle.
    if (advance_rd) begin
      valid_d[rd_ptr_q]  = 1'b0;
      killed_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PTR_W'(1);
    end

    // The write slot is always free here because store implies not full.
    if (store) begin
      valid_d[wr_ptr_q]  = 1'b1;
      killed_d[wr_ptr_q] = push_kill;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end

    usage_d = usage_q + CNT_W'(store) - CNT_W'(advance_rd);

    if (flush_i) begin
      valid_d  = '0;
      killed_d = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end
  end

  // Control state register; reset clears every flag so old contents are lost at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      valid_q  <= '0;
      killed_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      killed_q <= killed_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Payload storage, written only on a real store.
  always_ff @(posedge clk_i) begin
    // NOTE: the payload array is not reset; valid/killed flags decide whether an entry counts
    // and pop data is forced to zero while empty.
    if (store) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign pop_valid_o = pop_valid;
  assign pop_instr_o = pop_entry.instr;
  assign pop_rs1_o   = pop_entry.rs1;
  assign pop_rs2_o   = pop_entry.rs2;
  assign pop_id_o    = pop_entry.id;
  assign usage_o     = usage_q;
  assign full_o      = full;
  assign empty_o     = empty;

endmodule : fpu_ss_instr_buffer

// File: tb/tb_fpu_ss_instr_buffer.sv
// Directed bench for fpu_ss_instr_buffer: a registered instance and a fall-through
// instance share one stimulus stream.
module tb_fpu_ss_instr_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        push_valid_i;
  logic [31:0] push_instr_i;
  logic [31:0] push_rs1_i;
  logic [31:0] push_rs2_i;
  logic [3:0]  push_id_i;
  logic        kill_valid_i;
  logic [3:0]  kill_id_i;
  logic        pop_ready_i;

  logic        push_ready_o, pop_valid_o, full_o, empty_o;
  logic [31:0] pop_instr_o, pop_rs1_o, pop_rs2_o;
  logic [3:0]  pop_id_o;
  logic [2:0]  usage_o;

  logic        push_ready_ft, pop_valid_ft, full_ft, empty_ft;
  logic [31:0] pop_instr_ft, pop_rs1_ft, pop_rs2_ft;
  logic [3:0]  pop_id_ft;
  logic [2:0]  usage_ft;

  int vectors     = 0;
  int miscompares = 0;

  fpu_ss_instr_buffer #(.DEPTH(4), .FALL_THROUGH(1'b0), .ID_WIDTH(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_instr_i(push_instr_i), .push_rs1_i(push_rs1_i), .push_rs2_i(push_rs2_i),
    .push_id_i(push_id_i), .kill_valid_i(kill_valid_i), .kill_id_i(kill_id_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .pop_instr_o(pop_instr_o), .pop_rs1_o(pop_rs1_o), .pop_rs2_o(pop_rs2_o),
    .pop_id_o(pop_id_o), .usage_o(usage_o), .full_o(full_o), .empty_o(empty_o)
  );

  fpu_ss_instr_buffer #(.DEPTH(4), .FALL_THROUGH(1'b1), .ID_WIDTH(4)) u_dut_ft (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_ft),
    .push_instr_i(push_instr_i), .push_rs1_i(push_rs1_i), .push_rs2_i(push_rs2_i),
    .push_id_i(push_id_i), .kill_valid_i(kill_valid_i), .kill_id_i(kill_id_i),
    .pop_valid_o(pop_valid_ft), .pop_ready_i(pop_ready_i),
    .pop_instr_o(pop_instr_ft), .pop_rs1_o(pop_rs1_ft), .pop_rs2_o(pop_rs2_ft),
    .pop_id_o(pop_id_ft), .usage_o(usage_ft), .full_o(full_ft), .empty_o(empty_ft)
  );

  always #5 clk_i = ~clk_i;

  // Payload patterns derived from the id so data order can be checked.
  function automatic logic [31:0] exp_instr(input logic [3:0] id);
    return 32'hA000_0000 | {28'h0, id};
  endfunction
  function automatic logic [31:0] exp_rs1(input logic [3:0] id);
    return 32'h0000_1000 + {28'h0, id};
  endfunction
  function automatic logic [31:0] exp_rs2(input logic [3:0] id);
    return 32'h0000_2000 + {28'h0, id};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    flush_i      = 1'b0;
    push_valid_i = 1'b0;
    push_instr_i = '0;
    push_rs1_i   = '0;
    push_rs2_i   = '0;
    push_id_i    = '0;
    kill_valid_i = 1'b0;
    kill_id_i    = '0;
    pop_ready_i  = 1'b0;
  endtask

  task automatic set_push(input logic [3:0] id);
    push_valid_i = 1'b1;
    push_id_i    = id;
    push_instr_i = exp_instr(id);
    push_rs1_i   = exp_rs1(id);
    push_rs2_i   = exp_rs2(id);
  endtask

  task automatic clr_push();
    push_valid_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    settle();

    // Reset state
    chk("rst_push_ready", 32'(push_ready_o), 32'd1);
    chk("rst_pop_valid",  32'(pop_valid_o),  32'd0);
    chk("rst_empty",      32'(empty_o),      32'd1);
    chk("rst_full",       32'(full_o),       32'd0);
    chk("rst_usage",      32'(usage_o),      32'd0);
    chk("rst_pop_instr",  pop_instr_o,       32'd0);

    // Fill and drain
    for (int k = 0; k < 4; k++) begin
      set_push(4'(k));
      settle();
      chk("fill_ready", 32'(push_ready_o), 32'd1);
      tick();
    end
    set_push(4'd4);
    settle();
    chk("fill_full",      32'(full_o),       32'd1);
    chk("fill_ready_off", 32'(push_ready_o), 32'd0);
    chk("fill_usage",     32'(usage_o),      32'd4);
    tick();
    clr_push();
    settle();
    chk("full_hold_usage", 32'(usage_o), 32'd4);
    pop_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("drain_valid", 32'(pop_valid_o), 32'd1);
      chk("drain_id",    32'(pop_id_o),    32'(k));
      chk("drain_instr", pop_instr_o,      exp_instr(4'(k)));
      chk("drain_rs2",   pop_rs2_o,        exp_rs2(4'(k)));
      tick();
    end
    chk("drain_empty", 32'(empty_o),     32'd1);
    chk("drain_valid0", 32'(pop_valid_o), 32'd0);
    chk("drain_usage", 32'(usage_o),     32'd0);
    chk("drain_data0", pop_instr_o,      32'd0);
    pop_ready_i = 1'b0;

    // Kill middle entry
    for (int k = 1; k < 4; k++) begin
      set_push(4'(k));
      tick();
    end
    clr_push();
    kill_valid_i = 1'b1;
    kill_id_i    = 4'd2;
    pop_ready_i  = 1'b1;
    settle();
    chk("km_pop1_valid", 32'(pop_valid_o), 32'd1);
    chk("km_pop1_id",    32'(pop_id_o),    32'd1);
    tick();
    kill_valid_i = 1'b0;
    settle();
    chk("km_drop_valid", 32'(pop_valid_o), 32'd0);
    chk("km_drop_usage", 32'(usage_o),     32'd2);
    tick();
    chk("km_pop3_valid", 32'(pop_valid_o), 32'd1);
    chk("km_pop3_id",    32'(pop_id_o),    32'd3);
    chk("km_pop3_usage", 32'(usage_o),     32'd1);
    tick();
    chk("km_end_usage",  32'(usage_o),     32'd0);
    chk("km_end_empty",  32'(empty_o),     32'd1);
    pop_ready_i = 1'b0;

    // Kill and push of the same id in one cycle
    set_push(4'd5);
    kill_valid_i = 1'b1;
    kill_id_i    = 4'd5;
    tick();
    clr_push();
    kill_valid_i = 1'b0;
    settle();
    chk("kp_usage1", 32'(usage_o),     32'd1);
    chk("kp_valid0", 32'(pop_valid_o), 32'd0);
    tick();
    chk("kp_usage0", 32'(usage_o),     32'd0);
    chk("kp_empty",  32'(empty_o),     32'd1);

    // Kill of absent id, then kill and pop of the head together
    set_push(4'd7);
    tick();
    set_push(4'd8);
    tick();
    clr_push();
    kill_valid_i = 1'b1;
    kill_id_i    = 4'hC;
    tick();
    kill_valid_i = 1'b0;
    settle();
    chk("absent_usage", 32'(usage_o),     32'd2);
    chk("absent_valid", 32'(pop_valid_o), 32'd1);
    kill_valid_i = 1'b1;
    kill_id_i    = 4'd7;
    pop_ready_i  = 1'b1;
    settle();
    chk("kpop_valid", 32'(pop_valid_o), 32'd1);
    chk("kpop_id",    32'(pop_id_o),    32'd7);
    tick();
    kill_valid_i = 1'b0;
    settle();
    chk("kpop_next_valid", 32'(pop_valid_o), 32'd1);
    chk("kpop_next_id",    32'(pop_id_o),    32'd8);
    chk("kpop_next_usage", 32'(usage_o),     32'd1);
    tick();
    chk("kpop_end_usage",  32'(usage_o),     32'd0);
    pop_ready_i = 1'b0;

    // Wrap-around at steady usage 2
    set_push(4'hA);
    tick();
    set_push(4'hB);
    tick();
    pop_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_push(4'(12 + i));
      settle();
      chk("wrap_id",    32'(pop_id_o), 32'((10 + i) % 16));
      chk("wrap_rs1",   pop_rs1_o,     exp_rs1(4'((10 + i) % 16)));
      chk("wrap_usage", 32'(usage_o),  32'd2);
      tick();
    end
    clr_push();
    settle();
    chk("wrap_tail_id0", 32'(pop_id_o), 32'd4);
    tick();
    chk("wrap_tail_id1", 32'(pop_id_o), 32'd5);
    tick();
    chk("wrap_empty", 32'(empty_o), 32'd1);
    pop_ready_i = 1'b0;

    // Flush with three entries and a pending push
    for (int k = 1; k < 4; k++) begin
      set_push(4'(k));
      tick();
    end
    set_push(4'd4);
    flush_i = 1'b1;
    settle();
    chk("flush_ready", 32'(push_ready_o), 32'd0);
    chk("flush_valid", 32'(pop_valid_o),  32'd1);
    tick();
    flush_i = 1'b0;
    clr_push();
    settle();
    chk("flush_usage", 32'(usage_o),     32'd0);
    chk("flush_empty", 32'(empty_o),     32'd1);
    chk("flush_pv",    32'(pop_valid_o), 32'd0);

    // Reset pulsed mid-stream
    set_push(4'd1);
    tick();
    set_push(4'd2);
    tick();
    clr_push();
    settle();
    chk("pre_rst_usage", 32'(usage_o), 32'd2);
    rst_i = 1'b1;
    settle();
    chk("mid_rst_pv",    32'(pop_valid_o),  32'd0);
    chk("mid_rst_usage", 32'(usage_o),      32'd0);
    chk("mid_rst_ready", 32'(push_ready_o), 32'd1);
    tick();
    rst_i = 1'b0;
    settle();

    // Fall-through: same-cycle bypass with pop_ready high
    set_push(4'd6);
    pop_ready_i = 1'b1;
    settle();
    chk("ft_byp_valid", 32'(pop_valid_ft), 32'd1);
    chk("ft_byp_id",    32'(pop_id_ft),    32'd6);
    chk("ft_byp_rs1",   pop_rs1_ft,        exp_rs1(4'd6));
    chk("reg_byp_pv",   32'(pop_valid_o),  32'd0);
    tick();
    clr_push();
    pop_ready_i = 1'b0;
    settle();
    chk("ft_byp_usage",  32'(usage_ft),    32'd0);
    chk("reg_byp_usage", 32'(usage_o),     32'd1);
    chk("reg_lat_valid", 32'(pop_valid_o), 32'd1);
    chk("reg_lat_id",    32'(pop_id_o),    32'd6);

    // Fall-through: bypass visible but not consumed, so it is stored
    set_push(4'd6);
    settle();
    chk("ft_store_pv", 32'(pop_valid_ft), 32'd1);
    tick();
    clr_push();
    settle();
    chk("ft_store_usage", 32'(usage_ft),  32'd1);
    chk("ft_store_id",    32'(pop_id_ft), 32'd6);
    pop_ready_i = 1'b1;
    tick();
    tick();
    chk("ft_drain_usage",  32'(usage_ft), 32'd0);
    chk("reg_drain_usage", 32'(usage_o),  32'd0);

    // Fall-through: kill on the bypassed id hides it and stores it killed
    set_push(4'd9);
    kill_valid_i = 1'b1;
    kill_id_i    = 4'd9;
    settle();
    chk("ft_kill_pv", 32'(pop_valid_ft), 32'd0);
    tick();
    clr_push();
    kill_valid_i = 1'b0;
    settle();
    chk("ft_kill_usage1", 32'(usage_ft),     32'd1);
    chk("ft_kill_pv2",    32'(pop_valid_ft), 32'd0);
    tick();
    chk("ft_kill_usage0", 32'(usage_ft),     32'd0);
    pop_ready_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fpu_ss_instr_buffer
